pipe_stage_skid: RTL and testbench
==================================

# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, an optional two-entry skid buffer, and a synchronous flush. It generalises the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block carrying an opaque payload. Any stage can therefore back-pressure its predecessor without a combinational ready chain. It also counts output stall cycles for performance monitoring.

## Interface
- DATA_W, 32, payload width in bits (concatenated stage fields); ≥1
- SKID_EN, 1, 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
- CLEAR_DATA, 1, 1 = flush and reset zero the stored payload; 0 = flush only drops valid
- CNT_W, 16, width of stall counter; ≥1

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high reset (one clock; reset synchronous, active-high)
- flush  in  1  synchronous clear: discard all held and incoming entries
- in_valid  in  1  upstream has payload
- in_ready  out  1  stage can accept payload
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  stage presents payload
- out_ready  in  1  downstream accepts payload
- out_data  out  DATA_W  presented payload
- occupancy  out  2  entries held (0..2; max 1 when SKID_EN=0)
- stall_cnt  out  CNT_W  saturating count of stalled output cycles

## Operation
- Accept = in_valid & in_ready; emit = out_valid & out_ready, both sampled at the rising clock edge.
- Storage: main register (drives out_data) plus a skid register when SKID_EN=1.
- States for SKID_EN=1 are EMPTY, FULL and SKID. out_valid=1 in FULL and SKID. in_ready=0 only in SKID.
  - EMPTY: accept → FULL, main←in_data.
  - FULL: accept&emit → FULL, main←in_data; accept only → SKID, skid←in_data; emit only → EMPTY; neither → hold.
  - SKID: emit → FULL, main←skid; otherwise hold. No accept is possible in SKID.
- For SKID_EN=0, in_ready = ~out_valid | out_ready. States are EMPTY and FULL only. FULL with accept&emit → main←in_data.
- Order is strictly FIFO. No payload is ever duplicated or dropped, except on flush.
- Priority: reset > flush > handshake.
- flush: the next state is EMPTY, occupancy=0 and out_valid=0. Any payload accepted in the flush cycle is discarded. An emit in the flush cycle still counts as delivered downstream. When CLEAR_DATA=1, main and skid are zeroed; otherwise the data is held.
- out_data holds its last value while out_valid=0, or 0 after flush/reset when CLEAR_DATA=1.
- stall_cnt increments by 1 each cycle with out_valid=1 & out_ready=0. It saturates at 2^CNT_W−1 with no wrap. It is cleared by reset only; flush does not clear it.
- Payload is transferred bit-exact with no width conversion.

## Timing
- Reset values: out_valid=0, out_data=0, occupancy=0, stall_cnt=0, in_ready=1 (both SKID_EN modes).
- Latency: a payload accepted at edge N is on out_data with out_valid=1 after edge N (visible in cycle N+1).
- Throughput: 1 payload per cycle while out_ready=1.
- SKID_EN=1: in_ready is a register output with no combinational path from out_ready. SKID_EN=0: in_ready depends combinationally on out_ready.
- Once asserted, out_valid stays high with out_data stable until emit, flush or reset.
- The flush→accept path is immediate: a payload accepted in the cycle after flush is handled normally.
- Reset mid-transfer: all entries are lost and outputs take their reset values at the next edge.

## Test plan
- Streaming, SKID_EN=1, DATA_W=32: in_valid=1 with data 1,2,3,4 on consecutive cycles, out_ready=1 → out_data 1,2,3,4 one cycle later each; occupancy=1 throughout; stall_cnt=0.
- Back-pressure into skid: send 0xA, 0xB while out_ready=0 → occupancy 1 then 2, in_ready=0, out_data=0xA held; stall_cnt counts 1,2,…. Raise out_ready → 0xA then 0xB emitted, in_ready=1 one cycle after the first emit.
- Flush with occupancy=2 and in_valid=1 (data 0xC) → next cycle out_valid=0, occupancy=0, out_data=0 (CLEAR_DATA=1); 0xC is never emitted; stall_cnt is retained.
- SKID_EN=0: FULL with out_ready=0 → in_ready=0. Raise out_ready while in_valid=1 (0x55) in the same cycle → in_ready=1 in that cycle, the old entry is emitted and 0x55 appears on the next cycle.
- Counter saturation, CNT_W=3: hold out_valid=1 and out_ready=0 for 10 cycles → stall_cnt reaches 7 and stays at 7.
- Synchronous reset asserted in SKID state → after one edge, all outputs equal their reset values; a payload sent afterwards flows with 1-cycle latency.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and optional two-entry skid buffer.
// Carries an opaque payload, supports synchronous flush and counts stalled output cycles.
module pipe_stage_skid #(
  parameter int DATA_W     = 32,
  parameter int SKID_EN    = 1,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};

  state_t            state_reg;
  logic [DATA_W-1:0] main_reg;
  logic [DATA_W-1:0] skid_reg;
  logic              valid_reg;
  logic              ready_reg;
  logic [1:0]        occ_reg;
  logic [CNT_W-1:0]  stall_reg;
  logic              accept;
  logic              emit;

  assign accept = in_valid & in_ready;
  assign emit   = valid_reg & out_ready;

  // ready_reg never drops without the skid entry, so the single-register form
  // reduces to the classic combinational ~valid | ready.
  generate
    if (SKID_EN != 0) begin : g_skid
      assign in_ready = ready_reg;
    end else begin : g_noskid
      assign in_ready = ready_reg & (~valid_reg | out_ready);
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
      valid_reg <= 1'b0;
      ready_reg <= 1'b1;
      occ_reg   <= 2'd0;
    end else if (flush) begin
      state_reg <= ST_EMPTY;
      valid_reg <= 1'b0;
      ready_reg <= 1'b1;
      occ_reg   <= 2'd0;
      if (CLEAR_DATA != 0) begin
        main_reg <= '0;
        skid_reg <= '0;
      end
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            main_reg  <= in_data;
            valid_reg <= 1'b1;
            occ_reg   <= 2'd1;
            state_reg <= ST_FULL;
          end
        end
        ST_FULL: begin
          if (accept && emit) begin
            main_reg <= in_data;
          end else if (accept && (SKID_EN != 0)) begin
            skid_reg  <= in_data;
            ready_reg <= 1'b0;
            occ_reg   <= 2'd2;
            state_reg <= ST_SKID;
          end else if (emit) begin
            valid_reg <= 1'b0;
            occ_reg   <= 2'd0;
            state_reg <= ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (emit) begin
            main_reg  <= skid_reg;
            ready_reg <= 1'b1;
            occ_reg   <= 2'd1;
            state_reg <= ST_FULL;
          end
        end
        default: begin
          state_reg <= ST_EMPTY;
          valid_reg <= 1'b0;
          ready_reg <= 1'b1;
          occ_reg   <= 2'd0;
        end
      endcase
    end
  end

  // Flush does not clear the counter; a stalled flush cycle still counts.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_reg <= '0;
    end else if (valid_reg && !out_ready && (stall_reg != STALL_MAX)) begin
      stall_reg <= stall_reg + CNT_W'(1);
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = main_reg;
  assign occupancy = occ_reg;
  assign stall_cnt = stall_reg;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed bench: skid instance, single-register instance (no data clear), and 3-bit counter instance.
module tb_pipe_stage_skid;
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  // SKID_EN=1, DATA_W=32, CLEAR_DATA=1, CNT_W=16
  logic        flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  occupancy;
  logic [15:0] stall_cnt;

  // SKID_EN=0, CLEAR_DATA=0
  logic        n_flush, n_in_valid, n_in_ready, n_out_valid, n_out_ready;
  logic [31:0] n_in_data, n_out_data;
  logic [1:0]  n_occupancy;
  logic [15:0] n_stall_cnt;

  // SKID_EN=1, DATA_W=8, CNT_W=3
  logic        s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [7:0]  s_in_data, s_out_data;
  logic [1:0]  s_occupancy;
  logic [2:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  pipe_stage_skid #(.DATA_W(32), .SKID_EN(1), .CLEAR_DATA(1), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy), .stall_cnt(stall_cnt));

  pipe_stage_skid #(.DATA_W(32), .SKID_EN(0), .CLEAR_DATA(0), .CNT_W(16)) dut_noskid (
    .clock(clock), .reset(reset), .flush(n_flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_data(n_in_data), .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data),
    .occupancy(n_occupancy), .stall_cnt(n_stall_cnt));

  pipe_stage_skid #(.DATA_W(8), .SKID_EN(1), .CLEAR_DATA(1), .CNT_W(3)) dut_sat (
    .clock(clock), .reset(reset), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
    .occupancy(s_occupancy), .stall_cnt(s_stall_cnt));

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got %0d exp 0", occupancy); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d exp 0", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL reset_noskid_in_ready got %b exp 1", n_in_ready); end
    $display("reset: valid=%b data=%h occ=%0d stall=%0d in_ready=%b", out_valid, out_data, occupancy, stall_cnt, in_ready);
  endtask

  task automatic test_streaming();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      tick();
      checks++; if (out_valid !== 1'b1 || out_data !== i) begin errors++; $display("FAIL stream_data got v=%b %h exp v=1 %h", out_valid, out_data, i); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ got %0d exp 1", occupancy); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall got %0d exp 0", stall_cnt); end
      $display("stream: sent %0d out_data=%h occ=%0d", i, out_data, occupancy);
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL stream_drain got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    checks++; if (out_data !== 32'h4) begin errors++; $display("FAIL stream_hold_data got %h exp 4", out_data); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    tick();
    checks++; if (occupancy !== 2'd1 || in_ready !== 1'b1 || out_data !== 32'hA) begin errors++; $display("FAIL bp_first got occ=%0d rdy=%b data=%h exp occ=1 rdy=1 data=a", occupancy, in_ready, out_data); end
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL bp_stall0 got %0d exp 0", stall_cnt); end
    in_data = 32'hB;
    tick();
    in_valid = 1'b0;
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin errors++; $display("FAIL bp_skid got occ=%0d rdy=%b data=%h exp occ=2 rdy=0 data=a", occupancy, in_ready, out_data); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL bp_stall1 got %0d exp 1", stall_cnt); end
    $display("bp: skid occ=%0d in_ready=%b stall=%0d", occupancy, in_ready, stall_cnt);
    for (int k = 2; k <= 3; k++) begin
      tick();
      checks++; if (stall_cnt !== 16'(k) || out_data !== 32'hA || occupancy !== 2'd2) begin errors++; $display("FAIL bp_hold got stall=%0d data=%h occ=%0d exp stall=%0d data=a occ=2", stall_cnt, out_data, occupancy, k); end
      $display("bp: hold stall=%0d", stall_cnt);
    end
    out_ready = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_registered got %b exp 0", in_ready); end
    tick();
    checks++; if (out_data !== 32'hB || out_valid !== 1'b1 || in_ready !== 1'b1 || occupancy !== 2'd1) begin errors++; $display("FAIL bp_emit_a got data=%h v=%b rdy=%b occ=%0d exp data=b v=1 rdy=1 occ=1", out_data, out_valid, in_ready, occupancy); end
    checks++; if (stall_cnt !== 16'd3) begin errors++; $display("FAIL bp_stall_after got %0d exp 3", stall_cnt); end
    tick();
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp_emit_b got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
    $display("bp: drained out_valid=%b", out_valid);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    tick();
    in_data = 32'h22;
    tick();
    checks++; if (occupancy !== 2'd2 || stall_cnt !== 16'd4) begin errors++; $display("FAIL flush_setup got occ=%0d stall=%0d exp occ=2 stall=4", occupancy, stall_cnt); end
    in_data = 32'hC;
    flush   = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_data !== 32'h0) begin errors++; $display("FAIL flush_clear got v=%b occ=%0d data=%h exp v=0 occ=0 data=0", out_valid, occupancy, out_data); end
    checks++; if (stall_cnt !== 16'd5 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_stall got stall=%0d rdy=%b exp stall=5 rdy=1", stall_cnt, in_ready); end
    $display("flush: valid=%b occ=%0d data=%h stall=%0d", out_valid, occupancy, out_data, stall_cnt);
    out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped got v=%b exp 0", out_valid); end
    in_valid = 1'b1;
    in_data  = 32'h33;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h33) begin errors++; $display("FAIL flush_then_accept got v=%b data=%h exp v=1 data=33", out_valid, out_data); end
    tick();
    $display("flush: post-flush payload %h delivered", 32'h33);
  endtask

  task automatic test_no_skid();
    n_out_ready = 1'b0;
    n_in_valid  = 1'b1;
    n_in_data   = 32'h44;
    tick();
    n_in_data = 32'h55;
    #1;
    checks++; if (n_in_ready !== 1'b0 || n_occupancy !== 2'd1) begin errors++; $display("FAIL noskid_full_ready got rdy=%b occ=%0d exp rdy=0 occ=1", n_in_ready, n_occupancy); end
    tick();
    checks++; if (n_out_data !== 32'h44 || n_occupancy !== 2'd1) begin errors++; $display("FAIL noskid_hold got data=%h occ=%0d exp data=44 occ=1", n_out_data, n_occupancy); end
    n_out_ready = 1'b1;
    #1;
    checks++; if (n_in_ready !== 1'b1) begin errors++; $display("FAIL noskid_comb_ready got %b exp 1", n_in_ready); end
    tick();
    n_in_valid  = 1'b0;
    n_out_ready = 1'b0;
    checks++; if (n_out_data !== 32'h55 || n_out_valid !== 1'b1 || n_occupancy !== 2'd1) begin errors++; $display("FAIL noskid_replace got data=%h v=%b occ=%0d exp data=55 v=1 occ=1", n_out_data, n_out_valid, n_occupancy); end
    $display("noskid: out_data=%h after simultaneous accept/emit", n_out_data);
    n_flush = 1'b1;
    tick();
    n_flush = 1'b0;
    checks++; if (n_out_valid !== 1'b0 || n_occupancy !== 2'd0 || n_out_data !== 32'h55) begin errors++; $display("FAIL noskid_flush got v=%b occ=%0d data=%h exp v=0 occ=0 data=55", n_out_valid, n_occupancy, n_out_data); end
    checks++; if (n_stall_cnt !== 16'd2 || n_in_ready !== 1'b1) begin errors++; $display("FAIL noskid_stall got stall=%0d rdy=%b exp stall=2 rdy=1", n_stall_cnt, n_in_ready); end
    $display("noskid: flushed data held=%h stall=%0d", n_out_data, n_stall_cnt);
  endtask

  task automatic test_saturation();
    logic [2:0] exp_tbl [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7, 3'd7};
    s_out_ready = 1'b0;
    s_in_valid  = 1'b1;
    s_in_data   = 8'h7;
    tick();
    s_in_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++; if (s_stall_cnt !== exp_tbl[k] || s_out_valid !== 1'b1) begin errors++; $display("FAIL sat_cycle%0d got stall=%0d v=%b exp stall=%0d v=1", k + 1, s_stall_cnt, s_out_valid, exp_tbl[k]); end
      $display("sat: stalled cycle %0d stall_cnt=%0d", k + 1, s_stall_cnt);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h61;
    tick();
    in_data = 32'h62;
    tick();
    checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL rstmid_setup got occ=%0d rdy=%b exp occ=2 rdy=0", occupancy, in_ready); end
    in_data = 32'h63;
    reset   = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0 || out_data !== 32'h0 || occupancy !== 2'd0) begin errors++; $display("FAIL rstmid_outputs got v=%b data=%h occ=%0d exp v=0 data=0 occ=0", out_valid, out_data, occupancy); end
    checks++; if (stall_cnt !== 16'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_stall got stall=%0d rdy=%b exp stall=0 rdy=1", stall_cnt, in_ready); end
    checks++; if (s_stall_cnt !== 3'd0 || s_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_sat got stall=%0d v=%b exp stall=0 v=0", s_stall_cnt, s_out_valid); end
    $display("reset_mid: valid=%b occ=%0d stall=%0d", out_valid, occupancy, stall_cnt);
    out_ready = 1'b1;
    in_data   = 32'h70;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h70) begin errors++; $display("FAIL rstmid_flow got v=%b data=%h exp v=1 data=70", out_valid, out_data); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_drain got v=%b exp 0", out_valid); end
    $display("reset_mid: payload %h flowed after reset", 32'h70);
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    n_flush = 1'b0; n_in_valid = 1'b0; n_in_data = '0; n_out_ready = 1'b0;
    s_flush = 1'b0; s_in_valid = 1'b0; s_in_data = '0; s_out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_no_skid();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
